// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: freeze on data-memory wait, flush on a taken branch, one-cycle load-use stall.
// Enables and clears are combinational from the inputs; the statistics and watchdog flag update on the next edge.
module hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_rd_wren,
   input  logic             ex_is_load,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   input  logic             clr_stat,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_clr,
   output logic             idex_en,
   output logic             idex_clr,
   output logic             exmem_en,
   output logic             exmem_clr,
   output logic             memwb_en,
   output logic             memwb_clr,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   localparam int          WW        = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   state_t             state_q, state_d;
   logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   flush_q, flush_d;
   logic               timeout_q, timeout_d;

   logic freeze, flush, load_use, stall;

   always_comb begin
      load_use = ex_is_load && ex_rd_wren && (ex_rd_addr != 5'd0) &&
                 ((id_rs1_use && (id_rs1_addr == ex_rd_addr)) ||
                  (id_rs2_use && (id_rs2_addr == ex_rd_addr)));
      freeze   = mem_req && !mem_ack;
      flush    = !freeze && ex_br_taken;
      // A flush discards the ID instruction, so its dependency no longer matters.
      stall    = !freeze && !ex_br_taken && load_use;
   end

   always_comb begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      ifid_clr  = 1'b0;
      idex_en   = 1'b1;
      idex_clr  = 1'b0;
      exmem_en  = 1'b1;
      exmem_clr = 1'b0;
      memwb_en  = 1'b1;
      memwb_clr = 1'b0;
      if (freeze) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         exmem_en  = 1'b0;
         memwb_clr = 1'b1;
      end else if (flush) begin
         ifid_clr  = 1'b1;
         idex_clr  = 1'b1;
      end else if (stall) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_clr  = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      stall_d    = stall_q;
      flush_d    = flush_q;
      timeout_d  = timeout_q;

      case (state_q)
         S_RUN:   if (freeze)  state_d = S_WAIT;
         S_WAIT:  if (!freeze) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase

      if (freeze) begin
         if (wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + WW'(1);
      end else if (state_q == S_WAIT) begin
         wait_cnt_d = '0;
      end

      if (!pc_en && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
      if (flush && (flush_q != '1))  flush_d = flush_q + CNT_W'(1);
      if (freeze && (wait_cnt_q == WAIT_LAST)) timeout_d = 1'b1;

      // Clearing the statistics wins over any increment in the same cycle.
      if (clr_stat) begin
         stall_d   = '0;
         flush_d   = '0;
         timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
         timeout_q  <= timeout_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
   assign mem_timeout  = timeout_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit that drives the enable (`en`) and synchronous-clear (`syn_clr`) inputs of the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB. It also drives the PC register's enable. It resolves three hazard sources in a fixed priority order:

- data-memory wait (freeze),
- taken branch/jump resolved in EX (flush),
- load-use dependency (stall).

It also keeps a memory-wait watchdog and saturating stall/flush statistics counters. The block sits between the datapath stage decoders and every `register` instance in the pipeline.

## Interface
- `CNT_W`, default 16: width of the statistics counters.
- `MAX_WAIT`, default 64: number of consecutive freeze cycles after which `mem_timeout` sets (must be ≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs1_addr`, `id_rs2_addr`  in  5  source registers of the instruction in ID.
- `id_rs1_use`, `id_rs2_use`  in  1  the instruction in ID actually reads rs1/rs2.
- `ex_rd_addr`  in  5  destination register of the instruction in EX.
- `ex_rd_wren`  in  1  the instruction in EX writes rd.
- `ex_is_load`  in  1  the instruction in EX is a load.
- `ex_br_taken`  in  1  EX redirects the PC (taken branch or jump).
- `mem_req`  in  1  the instruction in MEM accesses data memory.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `clr_stat`  in  1  synchronous clear of the counters and `mem_timeout`.
- `pc_en`  out  1  enable for the PC register.
- `ifid_en`, `ifid_clr`  out  1 each  IF/ID controls.
- `idex_en`, `idex_clr`  out  1 each  ID/EX controls.
- `exmem_en`, `exmem_clr`  out  1 each  EX/MEM controls.
- `memwb_en`, `memwb_clr`  out  1 each  MEM/WB controls.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `pc_en`=0.
- `flush_count`  out  `CNT_W`  saturating count of branch flushes.
- `mem_timeout`  out  1  sticky watchdog flag.

## Operation
- Register semantics for the controlled registers:
  - `clr`=1 loads zero (a bubble); `clr` overrides `en`.
  - `en`=0 holds the register.
  - `en`=1 loads the register.
- Control outputs are combinational (Mealy) from the inputs and the state. The pipeline registers must see them in the same cycle.
- Priority 1, freeze, when `mem_req` && !`mem_ack`:
  - `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0;
  - `memwb_en`=1 and `memwb_clr`=1 (a bubble into WB);
  - all other clears are 0.
  - Branch and load-use conditions are ignored while frozen; they are re-evaluated once the freeze releases.
- Priority 2, flush, when `ex_br_taken` and not frozen:
  - `ifid_clr`=1 and `idex_clr`=1;
  - all enables are 1.
  - The load-use condition is ignored, because the ID instruction is being discarded.
- Priority 3, load-use stall, when `ex_is_load` && `ex_rd_wren` && `ex_rd_addr`≠0 && ((`id_rs1_use` && `id_rs1_addr`==`ex_rd_addr`) || (`id_rs2_use` && `id_rs2_addr`==`ex_rd_addr`)):
  - `pc_en`=0 and `ifid_en`=0;
  - `idex_clr`=1;
  - EX/MEM and MEM/WB advance.
  - The stall lasts exactly one cycle, because the load then moves to MEM.
- Otherwise: all enables are 1 and all clears are 0.
- FSM, states RUN and WAIT:
  - RUN→WAIT when a freeze occurs.
  - WAIT stays in WAIT while the freeze persists.
  - WAIT→RUN in the cycle `mem_ack`=1 or `mem_req`=0. In that cycle the pipeline advances normally.
- `wait_cnt` (internal):
  - increments on each freeze cycle;
  - clears on leaving WAIT;
  - saturates at `MAX_WAIT`.
- `mem_timeout`:
  - sets when a freeze cycle occurs with `wait_cnt`==`MAX_WAIT`-1, i.e. on the `MAX_WAIT`-th consecutive freeze cycle;
  - stays set until reset or `clr_stat`;
  - the freeze itself continues regardless.
- Statistics counters:
  - `stall_cycles` increments on every cycle with `pc_en`=0;
  - `flush_count` increments on every flush cycle;
  - both saturate at all-ones.
- `clr_stat` clears both counters and `mem_timeout` on the next edge and overrides any increment in the same cycle. It does not affect the FSM or `wait_cnt`.

## Timing
- Control path: zero latency, combinational from inputs to `*_en`/`*_clr`/`pc_en`.
- Statistics and flag update one cycle after the qualifying cycle.
- Reset (asynchronous, `rst_n`=0):
  - state=RUN, `wait_cnt`=0;
  - `stall_cycles`=0, `flush_count`=0, `mem_timeout`=0.
  - Combinational outputs follow the inputs with state=RUN.
- Reset asserted mid-WAIT returns the FSM to RUN immediately. No residual freeze is applied beyond what the current inputs dictate.
- Simultaneous `ex_br_taken` and load-use: flush only, no stall cycle counted.
- Simultaneous freeze and `ex_br_taken`: freeze only. The flush happens in the first unfrozen cycle if `ex_br_taken` is still asserted, and `flush_count` increments once.
- `mem_ack`=1 in the same cycle as `mem_req` rises: no freeze, state stays RUN.

## Test plan
- **Load-use:** EX=load x5 (`ex_rd_wren`=1), ID reads rs2=x5 with `id_rs2_use`=1 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_clr`=1; `stall_cycles`=1 on the next edge. Repeat with `ex_rd_addr`=0 → no stall.
- **Branch flush:** `ex_br_taken`=1 for one cycle while a load-use also matches → `ifid_clr`=`idex_clr`=1 and `pc_en`=1; `flush_count`=1; `stall_cycles` unchanged.
- **Memory wait:** `mem_req`=1 with `mem_ack` low for 3 cycles, then high → 3 cycles of freeze with `memwb_clr`=1; the ack cycle has all enables 1; state returns to RUN; `stall_cycles`=3.
- **Watchdog:** with `MAX_WAIT`=4, hold the freeze for 6 cycles → `mem_timeout` rises after the 4th freeze edge and stays 1 after ack; `clr_stat` pulse → 0.
- **Reset mid-WAIT:** assert `rst_n`=0 during the 2nd freeze cycle with `mem_req`=0 → state=RUN, counters=0, all enables 1 and clears 0.
- **Saturation:** with `CNT_W`=4, apply 20 load-use stalls → `stall_cycles`=15 and holds; `clr_stat` together with a stall in the same cycle → 0.
